arf_op_sched: RTL and testbench
===============================

ARF_OP_SCHED -- requirements
Module: arf_op_sched

Interface
REQ-001 The block SHALL expose parameter NREQ, default 4, number of requesters sharing the arithmetic unit.
REQ-002 The block SHALL expose parameter LAT, default 2, pipeline stages from issue to result-buffer write (LAT >= 1).
REQ-003 The block SHALL expose parameter SHIFT_WIDTH, default 8, the fixed-point right shift applied to products.
REQ-004 The block SHALL expose parameter RDEPTH, default 4, the result-buffer depth, a power of two.
REQ-005 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
REQ-009 req_op  in  NREQ  per-requester opcode, 0 = add, 1 = multiply.
REQ-010 req_mode  in  2*NREQ  per-requester accuracy mode, 0 = exact, 1 = approx-low, 2 = approx-high, 3 = reserved.
REQ-011 req_a, req_b  in  32*NREQ  per-requester operands.
REQ-012 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts.
REQ-013 rsp_id  out  clog2(NREQ)  originating requester; rsp_data  out  32  result.

Function
REQ-014 Arbitration SHALL be round-robin: grant the lowest index at or after pointer rr_ptr (wrapping) with req_valid set; on issue, rr_ptr becomes grant+1 mod NREQ.
REQ-015 At most one issue SHALL occur per cycle; req_ready SHALL depend combinationally on req_valid, rr_ptr and credit only.
REQ-016 Issue SHALL be allowed only while outstanding (in-flight plus buffered) < RDEPTH; otherwise req_ready SHALL be all-zero.
REQ-017 Add results: mode 0 a+b mod 2^32; mode 1 bits[31:8] = a[31:8]+b[31:8], bits[7:0] = 0; mode 2 bits[31:4] = a[31:4]+b[31:4], bits[3:0] = 0.
REQ-018 Multiply results: signed product of a[15:0] and b[15:0] as 32 bits, sign-extended to 64 bits, shifted right logically by SHIFT_WIDTH, low 32 bits kept; mode 1 zeroes operand bits[3:0] first, mode 2 zeroes operand bits[7:0] first.
REQ-019 Mode 3 SHALL execute as mode 0.
REQ-020 A result SHALL be written to the buffer exactly LAT cycles after its issue cycle, tagged with the grant index.
REQ-021 Results SHALL leave the buffer in issue order; rsp_valid = buffer non-empty; pop on rsp_valid and rsp_ready.
REQ-022 Simultaneous write and pop SHALL both take effect; occupancy unchanged when the buffer is full.
REQ-023 rsp_data and rsp_id SHALL hold stable while rsp_valid is high and rsp_ready is low.

Reset
REQ-024 Asserting rst_n low SHALL, asynchronously, clear rr_ptr to 0, discard all in-flight operations, empty the buffer, and drive rsp_valid and req_ready to 0; rsp_data and rsp_id SHALL reset to 0.
REQ-025 The first issue SHALL be possible in the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro ARF_SCHED_PERF_EN defined, the block SHALL add outputs perf_issue_cnt (32) counting issues and perf_stall_cnt (32) counting cycles with any req_valid high and no issue; both reset to 0 and wrap.
REQ-027 Without ARF_SCHED_PERF_EN, those ports and counters SHALL NOT exist.

Structure
REQ-028 The opcode encoding, mode encoding and default SHIFT_WIDTH SHALL live in the shared package arf_pkg.
REQ-029 The round-robin grant logic SHALL be the sub-module arf_rr_arb (inputs: request vector, pointer, enable; output: one-hot grant).

Verification
REQ-030 After reset, req_valid = 4'b1111, rsp_ready = 1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence is 0,1,2,3 starting LAT+1 cycles after the first issue.
REQ-031 Requester 2 issues add mode 1, a = 0x0000_01FF, b = 0x0000_0101 -> rsp_data = 0x0000_0200.
REQ-032 Requester 0 issues mul mode 0, a = 0xFFFF, b = 0x0100 -> rsp_data = 0xFFFF_FFFF (-256 >> 8).
REQ-033 rsp_ready = 0, all requesters valid -> exactly RDEPTH issues, then req_ready = 0; raising rsp_ready for 1 cycle frees exactly one credit.
REQ-034 rst_n pulsed low while 2 operations are in flight and the buffer holds 3 results -> rsp_valid = 0 immediately, no stale result ever appears, and the next grant goes to the lowest valid index.
REQ-035 With ARF_SCHED_PERF_EN, 10 cycles of full backpressure after 4 issues -> perf_issue_cnt = 4, perf_stall_cnt = 10.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared encodings and the arithmetic datapath for the operation scheduler.
package arf_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } arf_op_e;

    typedef enum logic [1:0] {
        MODE_EXACT     = 2'd0,
        MODE_APPROX_LO = 2'd1,
        MODE_APPROX_HI = 2'd2,
        MODE_RSVD      = 2'd3
    } arf_mode_e;

    localparam int ARF_SHIFT_WIDTH = 8;

    // Reserved mode falls through every approx branch and so behaves as exact.
    function automatic logic [31:0] arf_compute(
        input logic        op,
        input logic [1:0]  mode,
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned sh
    );
        logic [15:0]        a16;
        logic [15:0]        b16;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] prod;
        logic [63:0]        ext;
        logic [31:0]        res;
        a16 = a[15:0];
        b16 = b[15:0];
        res = a + b;
        if (op == OP_MUL) begin
            if (mode == MODE_APPROX_LO) begin
                a16[3:0] = '0;
                b16[3:0] = '0;
            end else if (mode == MODE_APPROX_HI) begin
                a16[7:0] = '0;
                b16[7:0] = '0;
            end
            sa   = 32'($signed(a16));
            sb   = 32'($signed(b16));
            prod = sa * sb;
            ext  = {{32{prod[31]}}, prod};
            ext  = ext >> sh;
            res  = ext[31:0];
        end else begin
            if (mode == MODE_APPROX_LO) begin
                res = {a[31:8] + b[31:8], 8'h00};
            end else if (mode == MODE_APPROX_HI) begin
                res = {a[31:4] + b[31:4], 4'h0};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arf_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping.
module arf_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_grant
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan from the pointer and stop at the first active request.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (i_en && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arf_op_sched.sv
// Arithmetic-unit scheduler: round-robin issue from NREQ requesters into a
// LAT-deep pipeline, results queued in an in-order buffer of RDEPTH entries.
// Optional perf counters are enabled by defining ARF_SCHED_PERF_EN.
module arf_op_sched
    import arf_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int LAT         = 2,
    parameter  int SHIFT_WIDTH = ARF_SHIFT_WIDTH,
    parameter  int RDEPTH      = 4,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data
`ifdef ARF_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int CW = $clog2(RDEPTH + 1);

    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_outst;
    logic            w_credit;
    logic [NREQ-1:0] w_grant;
    logic            w_issue;
    logic [IDW-1:0]  w_gidx;
    logic [31:0]     w_result;
    logic            w_wr;
    logic            w_pop;

    logic            r_pv    [LAT];
    logic [IDW-1:0]  r_pid   [LAT];
    logic [31:0]     r_pdata [LAT];

    logic [31:0]     r_mem_data [RDEPTH];
    logic [IDW-1:0]  r_mem_id   [RDEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(RDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover in-flight plus buffered results, so the buffer never overflows.
    // Gating with rst_n keeps grants low while reset is held.
    assign w_credit = rst_n && (r_outst < CW'(RDEPTH));

    arf_rr_arb #(.N(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_credit),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_issue   = |w_grant;
    assign w_wr      = r_pv[LAT-1];
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_data  = r_mem_data[r_rd_ptr];
    assign rsp_id    = r_mem_id[r_rd_ptr];

    // One-hot grant to index, then operand selection and result computation.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) w_gidx = IDW'(i);
        end
        w_result = arf_compute(req_op[w_gidx], req_mode[w_gidx*2 +: 2],
                               req_a[w_gidx*32 +: 32], req_b[w_gidx*32 +: 32],
                               SHIFT_WIDTH);
    end

    // Round-robin pointer and outstanding-operation credit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_outst  <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_pop);
        end
    end

    // Result pipeline: the last stage writes the buffer LAT cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_pv[s]    <= 1'b0;
                r_pid[s]   <= '0;
                r_pdata[s] <= '0;
            end
        end else begin
            r_pv[0]    <= w_issue;
            r_pid[0]   <= w_gidx;
            r_pdata[0] <= w_result;
            for (int s = 1; s < LAT; s++) begin
                r_pv[s]    <= r_pv[s-1];
                r_pid[s]   <= r_pid[s-1];
                r_pdata[s] <= r_pdata[s-1];
            end
        end
    end

    // In-order result buffer; entries are cleared so outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < RDEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_id[i]   <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem_data[r_wr_ptr] <= r_pdata[LAT-1];
                r_mem_id[r_wr_ptr]   <= r_pid[LAT-1];
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

`ifdef ARF_SCHED_PERF_EN
    // Issue count and stall count (requests pending but nothing issued).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (|req_valid && !w_issue) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arf_op_sched.sv
// Directed bench for arf_op_sched: vector table for the datapath plus
// hand-written sequences for arbitration, credits and reset.
module tb_arf_op_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_op = '0;
    logic [7:0]   req_mode = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_ready = 1'b0;

    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;

    logic [3:0]   req_ready8;
    logic         rsp_valid8;
    logic [1:0]   rsp_id8;
    logic [31:0]  rsp_data8;

`ifdef ARF_SCHED_PERF_EN
    logic [31:0]  perf_issue_cnt, perf_stall_cnt, perf_issue_cnt8, perf_stall_cnt8;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arf_op_sched #(.NREQ(NREQ), .LAT(LAT), .SHIFT_WIDTH(8), .RDEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ARF_SCHED_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Deeper instance so two in-flight plus three buffered results can coexist.
    arf_op_sched #(.NREQ(NREQ), .LAT(LAT), .SHIFT_WIDTH(8), .RDEPTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready8),
        .req_op(req_op), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_id(rsp_id8), .rsp_data(rsp_data8)
`ifdef ARF_SCHED_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt8), .perf_stall_cnt(perf_stall_cnt8)
`endif
    );

    typedef struct {
        int          id;
        logic        op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every requester: exact add of (i) + 0x100, so result = 0x100 + i.
    task automatic set_all_add();
        for (int i = 0; i < NREQ; i++) begin
            req_op[i]           = 1'b0;
            req_mode[i*2 +: 2]  = 2'd0;
            req_a[i*32 +: 32]   = 32'(i);
            req_b[i*32 +: 32]   = 32'h100;
        end
    endtask

    task automatic apply_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int waited;
        @(posedge clk);
        #1;
        req_valid               = '0;
        req_valid[v.id]         = 1'b1;
        req_op[v.id]            = v.op;
        req_mode[v.id*2 +: 2]   = v.mode;
        req_a[v.id*32 +: 32]    = v.a;
        req_b[v.id*32 +: 32]    = v.b;
        #1 chk("vec_grant", 32'(req_ready), 32'(1 << v.id));
        @(posedge clk);
        #1 req_valid = '0;
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(posedge clk);
            #1 waited++;
        end
        if (!rsp_valid) begin
            chk("vec_timeout", 32'(rsp_valid), 32'd1);
        end else begin
            chk("vec_latency", 32'(waited), 32'(LAT));
            chk("vec_data", rsp_data, v.exp);
            chk("vec_id", 32'(rsp_id), 32'(v.id));
        end
        @(posedge clk);
        #1 chk("vec_popped", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int issues;
        int seen;

        vecs[0]  = '{2, 1'b0, 2'd1, 32'h0000_01FF, 32'h0000_0101, 32'h0000_0200};
        vecs[1]  = '{0, 1'b1, 2'd0, 32'h0000_FFFF, 32'h0000_0100, 32'hFFFF_FFFF};
        vecs[2]  = '{1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[3]  = '{3, 1'b0, 2'd2, 32'h0000_001F, 32'h0000_0011, 32'h0000_0020};
        vecs[4]  = '{0, 1'b0, 2'd3, 32'h0000_0010, 32'h0000_0005, 32'h0000_0015};
        vecs[5]  = '{1, 1'b1, 2'd0, 32'h0000_1000, 32'h0000_0030, 32'h0000_0300};
        vecs[6]  = '{2, 1'b1, 2'd1, 32'h0000_0013, 32'h0000_0100, 32'h0000_0010};
        vecs[7]  = '{3, 1'b1, 2'd2, 32'h0000_01FF, 32'h0000_0200, 32'h0000_0200};
        vecs[8]  = '{0, 1'b1, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF, 32'h003F_FF00};
        vecs[9]  = '{1, 1'b1, 2'd0, 32'h0000_8000, 32'h0000_8000, 32'h0040_0000};
        vecs[10] = '{2, 1'b1, 2'd0, 32'h0001_FFFF, 32'h0000_0200, 32'hFFFF_FFFE};
        vecs[11] = '{3, 1'b0, 2'd1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000};

        // Reset state with all requesters asserting.
        rsp_ready = 1'b1;
        set_all_add();
        req_valid = 4'hF;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);

        // Round-robin order and response order/latency.
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c <= 4) chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c == 2) chk("rr_no_early_rsp", 32'(rsp_valid), 32'd0);
            if (c >= 3) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((c - 3) % 4));
                chk("rr_rsp_data", rsp_data, 32'h100 + 32'((c - 3) % 4));
            end
            @(posedge clk);
            #1;
            if (c == 4) req_valid = '0;
        end
        repeat (4) @(posedge clk);

        // Datapath vectors.
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: exactly RDEPTH issues, then one credit per pop.
        rsp_ready = 1'b0;
        set_all_add();
        req_valid = 4'hF;
        apply_reset();
        issues = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (|req_ready) issues++;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        chk("bp_issues", 32'(issues), 32'd4);
`ifdef ARF_SCHED_PERF_EN
        chk("perf_issue", perf_issue_cnt, 32'd4);
        chk("perf_stall", perf_stall_cnt, 32'd10);
`endif
        chk("bp_head_id", 32'(rsp_id), 32'd0);
        chk("bp_head_data", rsp_data, 32'h100);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_id", 32'(rsp_id), 32'd0);
        chk("bp_hold_data", rsp_data, 32'h100);
        req_valid = 4'hF;
        #1 chk("bp_full_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("bp_next_id", 32'(rsp_id), 32'd1);
        chk("bp_next_data", rsp_data, 32'h101);
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (|req_ready) issues++;
            @(posedge clk);
            #1;
        end
        chk("bp_one_credit", 32'(issues), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Reset with 2 in flight and 3 buffered in the deep instance.
        rsp_ready = 1'b0;
        set_all_add();
        req_valid = 4'hF;
        apply_reset();
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        chk("rip_pre_valid", 32'(rsp_valid8), 32'd1);
        chk("rip_pre_id", 32'(rsp_id8), 32'd0);
        req_valid = 4'b0101;
        #2 rst_n = 1'b0;
        #1;
        chk("rip_valid", 32'(rsp_valid8), 32'd0);
        chk("rip_ready", 32'(req_ready8), 32'd0);
        chk("rip_data", rsp_data8, 32'd0);
        chk("rip_id", 32'(rsp_id8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rip_first_grant", 32'(req_ready8), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid8) begin
                seen++;
                chk("rip_rsp_id", 32'(rsp_id8), 32'd0);
                chk("rip_rsp_data", rsp_data8, 32'h100);
            end
        end
        chk("rip_rsp_count", 32'(seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
